// File: rtl/cla_pkg.sv
// Shared constants, operation encoding and the flat carry-lookahead helper
// used by the grouped carry-lookahead add/subtract pipeline.
package cla_pkg;

  localparam int GRP_BITS   = 4;
  localparam int WIDTH_MIN  = 8;
  localparam int WIDTH_MAX  = 64;
  localparam int MAX_GROUPS = WIDTH_MAX / GRP_BITS;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Carry into position n of a (p, g) chain, written as a flat sum of
  // products: c0 & p[0..n-1] | OR_j g[j] & p[j+1..n-1]. Every call site
  // passes a constant n, so this collapses to one two-level AND-OR term
  // with no ripple through intermediate carries.
  function automatic logic lookahead_carry(
    input logic [MAX_GROUPS-1:0] p,
    input logic [MAX_GROUPS-1:0] g,
    input logic                  c0,
    input int                    n
  );
    logic c;
    logic t;
    c = c0;
    for (int k = 0; k < MAX_GROUPS; k++) begin
      if (k < n) c = c & p[k];
    end
    for (int j = 0; j < MAX_GROUPS; j++) begin
      if (j < n) begin
        t = g[j];
        for (int k = 0; k < MAX_GROUPS; k++) begin
          if (k > j && k < n) t = t & p[k];
        end
        c = c | t;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead slice: local sum from a, b and the
// group carry-in, plus the group propagate/generate seen by the upper levels.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       grp_p,
  output logic       grp_g
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign c[i] = lookahead_carry(MAX_GROUPS'(p), MAX_GROUPS'(g), c_in, i);
  end

  assign sum   = p ^ c;
  assign grp_p = &p;
  // g3 | p3g2 | p3p2g1 | p3p2p1g0
  assign grp_g = lookahead_carry(MAX_GROUPS'(p), MAX_GROUPS'(g), 1'b0, 4);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage add/subtract with valid/ready handshake on both sides.
// Stage 1 forms B' and per-group P/G; stage 2 resolves group carries with a
// two-level lookahead (groups within a unit, units across the word) and
// registers the sum and flags.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG   = WIDTH / GRP_BITS;
  localparam int NU   = (NG + GROUP - 1) / GROUP;
  localparam int NPAD = NU * GROUP;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % GRP_BITS) != 0) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH=%0d must be a multiple of 4 in 8..64", WIDTH);
  end
  if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_bad_group
    $error("pipelined_cla_addsub: GROUP=%0d must be 2, 4 or 8", GROUP);
  end

  // Handshake: stage 2 drains when empty or accepted downstream; stage 1
  // refills whenever it is empty or is about to move into stage 2.
  logic s1_valid;
  logic s2_valid;
  logic advance;
  logic accept;

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = rst_n && (!s1_valid || advance);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1 combinational: effective B and carry-free group P/G.
  op_e              in_op;
  logic [WIDTH-1:0] b_eff;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [WIDTH-1:0] pg_sum_unused;

  assign in_op = op_e'(in_sub);
  assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;

  // Stage 1 registers.
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  op_e              s1_op;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  // Stage 2 combinational.
  logic [NG-1:0]    grp_c;
  logic [WIDTH-1:0] sum_next;
  logic [NG-1:0]    s2_p_unused;
  logic [NG-1:0]    s2_g_unused;

  // Each group slice appears twice: once on the input operands for P/G,
  // once on the registered operands with its resolved carry for the sum.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_pg (
      .a     (in_a[gi*GRP_BITS +: GRP_BITS]),
      .b     (b_eff[gi*GRP_BITS +: GRP_BITS]),
      .c_in  (1'b0),
      .sum   (pg_sum_unused[gi*GRP_BITS +: GRP_BITS]),
      .grp_p (grp_p[gi]),
      .grp_g (grp_g[gi])
    );
    cla_group4 u_sum (
      .a     (s1_a[gi*GRP_BITS +: GRP_BITS]),
      .b     (s1_b[gi*GRP_BITS +: GRP_BITS]),
      .c_in  (grp_c[gi]),
      .sum   (sum_next[gi*GRP_BITS +: GRP_BITS]),
      .grp_p (s2_p_unused[gi]),
      .grp_g (s2_g_unused[gi])
    );
  end

  // Stage 1 occupancy: load a new beat (or a bubble) whenever there is room.
  always_ff @(posedge clk) begin
    // NOTE: all state uses <= so every flop samples pre-edge values.
    if (!rst_n) s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // Stage 1 datapath capture on an accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; s1_valid alone decides whether this data is live.
    if (accept) begin
      s1_a   <= in_a;
      s1_b   <= b_eff;
      s1_cin <= in_cin;
      s1_op  <= in_op;
      s1_gp  <= grp_p;
      s1_gg  <= grp_g;
    end
  end

  // Pad the group P/G out to whole units with transparent (P=1, G=0) slots.
  logic [NPAD-1:0] gp_pad;
  logic [NPAD-1:0] gg_pad;

  always_comb begin
    // NOTE: full defaults first so no path leaves a bit unassigned (no latch).
    gp_pad         = '1;
    gg_pad         = '0;
    gp_pad[NG-1:0] = s1_gp;
    gg_pad[NG-1:0] = s1_gg;
  end

  // Two-level lookahead: unit super-P/G, unit carries in flat form from the
  // word carry-in, then group carries in flat form from each unit carry.
  logic          c0;
  logic [NU-1:0] unit_p;
  logic [NU-1:0] unit_g;
  logic [NU-1:0] unit_c;
  logic          cout_next;
  logic          c_msb;

  assign c0 = (s1_op == OP_SUB) ? 1'b1 : s1_cin;

  for (genvar u = 0; u < NU; u++) begin : g_unit
    assign unit_p[u] = &gp_pad[u*GROUP +: GROUP];
    assign unit_g[u] = lookahead_carry(MAX_GROUPS'(gp_pad[u*GROUP +: GROUP]),
                                       MAX_GROUPS'(gg_pad[u*GROUP +: GROUP]), 1'b0, GROUP);
    assign unit_c[u] = lookahead_carry(MAX_GROUPS'(unit_p), MAX_GROUPS'(unit_g), c0, u);
    for (genvar j = 0; j < GROUP; j++) begin : g_slot
      if (u*GROUP + j < NG) begin : g_live
        assign grp_c[u*GROUP + j] = lookahead_carry(MAX_GROUPS'(gp_pad[u*GROUP +: GROUP]),
                                                    MAX_GROUPS'(gg_pad[u*GROUP +: GROUP]),
                                                    unit_c[u], j);
      end
    end
  end

  assign cout_next = lookahead_carry(MAX_GROUPS'(unit_p), MAX_GROUPS'(unit_g), c0, NU);
  // Carry into the MSB recovered from that bit's sum: c = a ^ b' ^ s.
  assign c_msb     = s1_a[WIDTH-1] ^ s1_b[WIDTH-1] ^ sum_next[WIDTH-1];

  // Stage 2 result register; holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= sum_next;
        out_cout <= cout_next;
        out_ovf  <= cout_next ^ c_msb;
        out_zero <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three lanes (8/G4, 32/G4, 64/G8).
// Directed vectors, backpressure and mid-flight reset run on the 32-bit lane;
// all lanes then run random traffic against an arithmetic reference model.
module tb_pipelined_cla_addsub;

  localparam int NL          = 3;
  localparam int RAND_CYCLES = 20000;
  localparam int NVEC        = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [NL];
  logic        in_ready  [NL];
  logic [63:0] in_a      [NL];
  logic [63:0] in_b      [NL];
  logic        in_sub    [NL];
  logic        in_cin    [NL];
  logic        out_valid [NL];
  logic        out_ready [NL];
  logic [63:0] out_sum   [NL];
  logic        out_cout  [NL];
  logic        out_ovf   [NL];
  logic        out_zero  [NL];

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int W = (k == 0) ? 8 : (k == 1) ? 32 : 64;
    localparam int G = (k == 2) ? 8 : 4;
    logic [W-1:0] sum_w;
    pipelined_cla_addsub #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_a      (in_a[k][W-1:0]),
      .in_b      (in_b[k][W-1:0]),
      .in_sub    (in_sub[k]),
      .in_cin    (in_cin[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_sum   (sum_w),
      .out_cout  (out_cout[k]),
      .out_ovf   (out_ovf[k]),
      .out_zero  (out_zero[k])
    );
    assign out_sum[k] = 64'(sum_w);
  end

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    res_t        exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl [NVEC];
  vec_t bp  [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: unsigned and signed results from plain wide arithmetic.
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input logic cin);
    res_t r;
    logic signed [66:0] ua, ub, us, sa, sb, exact, lim;
    ua = {3'b000, a};
    ub = {3'b000, b};
    if (sub) begin
      us     = ua - ub;
      r.cout = (a >= b);
    end else begin
      us     = ua + ub + {66'd0, cin};
      r.cout = us[w];
    end
    r.sum  = us[63:0] & wmask(w);
    sa     = a[w-1] ? ua - (67'sd1 << w) : ua;
    sb     = b[w-1] ? ub - (67'sd1 << w) : ub;
    exact  = sub ? sa - sb : sa + sb + $signed({66'd0, cin});
    lim    = 67'sd1 << (w - 1);
    r.ovf  = (exact >= lim) || (exact < -lim);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic sub,
                              input logic cin, input logic [63:0] sum, input logic cout,
                              input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.exp.sum = sum; v.exp.cout = cout; v.exp.ovf = ovf; v.exp.zero = zero;
    return v;
  endfunction

  function automatic logic [63:0] rand_operand(input int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return wmask(w);
      2:       return 64'd1 << (w - 1);
      3:       return wmask(w) >> 1;
      default: return {$urandom, $urandom} & wmask(w);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive1(input vec_t v, input logic valid);
    in_valid[1] = valid;
    in_a[1]     = v.a;
    in_b[1]     = v.b;
    in_sub[1]   = v.sub;
    in_cin[1]   = v.cin;
  endtask

  // Random traffic on one lane; expected results queue up in acceptance order.
  task automatic rand_lane(input int k, input int w);
    res_t q[$];
    res_t e;
    for (int c = 0; c < RAND_CYCLES + 12; c++) begin
      @(negedge clk);
      if (c < RAND_CYCLES) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        in_a[k]      = rand_operand(w);
        in_b[k]      = rand_operand(w);
        in_sub[k]    = 1'($urandom_range(0, 1));
        in_cin[k]    = 1'($urandom_range(0, 1));
      end else begin
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
      end
      #1;
      check($sformatf("rand_w%0d_in_ready", w), 128'(in_ready[k]),
            128'((q.size() < 2) || out_ready[k]));
      if (out_valid[k] && out_ready[k]) begin
        if (q.size() == 0) begin
          check($sformatf("rand_w%0d_outstanding", w), 128'(q.size()), 128'd1);
        end else begin
          e = q.pop_front();
          check($sformatf("rand_w%0d_sum", w), 128'(out_sum[k]), 128'(e.sum));
          check($sformatf("rand_w%0d_flags", w), 128'({out_cout[k], out_ovf[k], out_zero[k]}),
                128'({e.cout, e.ovf, e.zero}));
        end
      end
      if (in_valid[k] && in_ready[k])
        q.push_back(ref_model(w, in_a[k], in_b[k], in_sub[k], in_cin[k]));
    end
    check($sformatf("rand_w%0d_drained", w), 128'(q.size()), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sent;
    int   received;
    int   budget;
    res_t held;
    logic have_held;

    tbl[0]  = mk(64'h0000FFFF, 64'h00000001, 1'b0, 1'b0, 64'h00010000, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(64'hFFFFFFFF, 64'h00000001, 1'b0, 1'b0, 64'h00000000, 1'b1, 1'b0, 1'b1);
    tbl[2]  = mk(64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(64'h80000000, 64'h00000001, 1'b1, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(64'h00000005, 64'h00000005, 1'b1, 1'b0, 64'h00000000, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(64'h00000003, 64'h00000005, 1'b1, 1'b0, 64'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(64'h00000001, 64'h00000001, 1'b0, 1'b1, 64'h00000003, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(64'h80000000, 64'h80000000, 1'b0, 1'b0, 64'h00000000, 1'b1, 1'b1, 1'b1);
    tbl[9]  = mk(64'h00000000, 64'h00000001, 1'b1, 1'b0, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(64'h0000000A, 64'h00000003, 1'b1, 1'b1, 64'h00000007, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(64'h80000000, 64'h7FFFFFFF, 1'b1, 1'b0, 64'h00000001, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(64'h12345678, 64'h87654321, 1'b0, 1'b0, 64'h99999999, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(64'h7FFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bp[i]     = mk(64'(32'h1357_9BDF * (i + 1)), 64'(32'h0F0F_1234 + i), 1'(i % 2), 1'(i / 2 % 2),
                     64'd0, 1'b0, 1'b0, 1'b0);
      bp[i].exp = ref_model(32, bp[i].a, bp[i].b, bp[i].sub, bp[i].cin);
    end

    for (int k = 0; k < NL; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      in_a[k] = '0; in_b[k] = '0; in_sub[k] = 1'b0; in_cin[k] = 1'b0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready[1]), 128'd0);
    check("reset_out_valid", 128'(out_valid[1]), 128'd0);
    check("reset_out_sum", 128'(out_sum[1]), 128'd0);
    check("reset_flags", 128'({out_cout[1], out_ovf[1], out_zero[1]}), 128'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 128'(in_ready[1]), 128'd1);

    // Single beats: exact latency and result for each vector.
    out_ready[1] = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive1(tbl[i], 1'b1);
      #1;
      check($sformatf("tbl%0d_accept", i), 128'(in_ready[1]), 128'd1);
      next_cycle();
      in_valid[1] = 1'b0;
      #1;
      check($sformatf("tbl%0d_valid_early", i), 128'(out_valid[1]), 128'd0);
      next_cycle();
      #1;
      check($sformatf("tbl%0d_valid_on_time", i), 128'(out_valid[1]), 128'd1);
      check($sformatf("tbl%0d_sum", i), 128'(out_sum[1]), 128'(tbl[i].exp.sum));
      check($sformatf("tbl%0d_cout", i), 128'(out_cout[1]), 128'(tbl[i].exp.cout));
      check($sformatf("tbl%0d_ovf", i), 128'(out_ovf[1]), 128'(tbl[i].exp.ovf));
      check($sformatf("tbl%0d_zero", i), 128'(out_zero[1]), 128'(tbl[i].exp.zero));
      next_cycle();
      #1;
      check($sformatf("tbl%0d_valid_after", i), 128'(out_valid[1]), 128'd0);
    end

    // Backpressure: 6 stalled cycles, then drain all 5 beats in order.
    out_ready[1] = 1'b0;
    sent = 0;
    have_held = 1'b0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      drive1(bp[sent], 1'b1);
      #1;
      if (c >= 2) check($sformatf("bp_in_ready_low_c%0d", c), 128'(in_ready[1]), 128'd0);
      if (out_valid[1]) begin
        if (have_held)
          check($sformatf("bp_hold_c%0d", c),
                128'({out_sum[1], out_cout[1], out_ovf[1], out_zero[1]}), 128'(held));
        held      = '{sum: out_sum[1], cout: out_cout[1], ovf: out_ovf[1], zero: out_zero[1]};
        have_held = 1'b1;
      end
      if (in_valid[1] && in_ready[1]) sent++;
      next_cycle();
    end
    check("bp_accepted_before_stall", 128'(sent), 128'd2);
    check("bp_stalled_head", 128'(held), 128'(bp[0].exp));

    out_ready[1] = 1'b1;
    received = 0;
    budget   = 30;
    while (received < 5 && budget > 0) begin
      if (sent < 5) drive1(bp[sent], 1'b1);
      else in_valid[1] = 1'b0;
      #1;
      if (out_valid[1] && out_ready[1]) begin
        check($sformatf("bp_result%0d", received),
              128'({out_sum[1], out_cout[1], out_ovf[1], out_zero[1]}), 128'(bp[received].exp));
        received++;
      end
      if (in_valid[1] && in_ready[1]) sent++;
      next_cycle();
      budget--;
    end
    check("bp_delivered", 128'(received), 128'd5);
    in_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_no_duplicate_c%0d", c), 128'(out_valid[1]), 128'd0);
      next_cycle();
    end

    // Reset with two beats in flight.
    out_ready[1] = 1'b0;
    drive1(tbl[0], 1'b1);
    next_cycle();
    drive1(tbl[2], 1'b1);
    next_cycle();
    in_valid[1] = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    #1;
    check("rst_mid_out_valid", 128'(out_valid[1]), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready[1]), 128'd0);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release_ready", 128'(in_ready[1]), 128'd1);
    out_ready[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      #1;
      check($sformatf("rst_mid_no_stale_c%0d", c), 128'(out_valid[1]), 128'd0);
    end

    // Random traffic on all widths concurrently.
    fork
      rand_lane(0, 8);
      rand_lane(1, 32);
      rand_lane(2, 64);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
